// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory, delivers
// fetched words to IF/ID with stall hold, flush discard and a delivered-word counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clock__i,
  input  logic        reset_n__i,
  input  logic [31:0] address__i,
  input  logic        stall__i,
  input  logic        flush__i,
  input  logic        mem_ready__i,
  input  logic        mem_rvalid__i,
  input  logic [31:0] mem_rdata__i,
  output logic        mem_req__o,
  output logic [31:0] mem_addr__o,
  output logic        pcWrite__o,
  output logic [31:0] instruction__o,
  output logic [31:0] pc__o,
  output logic        valid__o,
  output logic [31:0] fetch_count__o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, pc_q, instr_q, fetch_cnt_q;
  logic        valid_q;
  logic        req, pc_write, load_instr, latch_pc, cnt_inc, clr_valid;

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    pc_write   = flush__i;
    load_instr = 1'b0;
    latch_pc   = 1'b0;
    cnt_inc    = 1'b0;
    clr_valid  = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req = 1'b1;
        // A grant coinciding with a flush still leaves a response in flight.
        if (mem_ready__i) begin
          latch_pc = !flush__i;
          state_d  = flush__i ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (flush__i) begin
          state_d = mem_rvalid__i ? REQ : DRAIN;
        end else if (mem_rvalid__i) begin
          load_instr = 1'b1;
          if (stall__i) begin
            state_d = HOLD;
          end else begin
            pc_write = 1'b1;
            cnt_inc  = 1'b1;
            state_d  = REQ;
          end
        end
      end
      HOLD: begin
        if (flush__i) begin
          state_d = REQ;
        end else if (!stall__i) begin
          pc_write  = 1'b1;
          cnt_inc   = 1'b1;
          clr_valid = 1'b1;
          state_d   = REQ;
        end
      end
      DRAIN: begin
        if (!flush__i && mem_rvalid__i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pc_q        <= '0;
      instr_q     <= RESET_INSTR;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (req)      addr_q <= address__i;
      if (latch_pc) pc_q   <= address__i;
      if (flush__i) begin
        instr_q <= RESET_INSTR;
        valid_q <= 1'b0;
      end else if (load_instr) begin
        instr_q <= mem_rdata__i;
        valid_q <= 1'b1;
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end
      fetch_cnt_q <= fetch_cnt_q + {31'd0, cnt_inc};
    end
  end

  // Address is live while requesting, otherwise the last requested value.
  assign mem_req__o     = req;
  assign mem_addr__o    = req ? address__i : addr_q;
  assign pcWrite__o     = pc_write;
  assign instruction__o = instr_q;
  assign pc__o          = pc_q;
  assign valid__o       = valid_q;
  assign fetch_count__o = fetch_cnt_q;

endmodule
